// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: runs one bus cycle per valid/ready command and
// returns read data or a timeout error over a valid/ready response channel.
module wb_cmd_master #(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [ADR_W-1:0]   cmd_adr,
  input  logic [DAT_W-1:0]   cmd_dat,
  input  logic [DAT_W/8-1:0] cmd_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DAT_W-1:0]   rsp_dat,
  output logic               rsp_err,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [DAT_W/8-1:0] wbm_sel_o,
  output logic [ADR_W-1:0]   wbm_adr_o,
  output logic [DAT_W-1:0]   wbm_dat_o,
  input  logic               wbm_ack_i,
  input  logic [DAT_W-1:0]   wbm_dat_i,
  output logic               busy
);

  localparam int SEL_W = DAT_W / 8;
  localparam logic TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               live_q, live_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   dat_q, dat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic               rsp_err_q, rsp_err_d;
  logic               accept_s;
  logic               timeout_hit_s;

  // live_q keeps cmd_ready low until the first edge after reset release
  assign accept_s      = cmd_valid && live_q && (state_q == S_IDLE);
  assign timeout_hit_s = TO_EN && (cnt_q == TO_LAST);

  // State and output registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q     <= S_IDLE;
      live_q      <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      live_q      <= live_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state decode; an ack on the final timeout cycle wins over the abort
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_BUS;
        else          state_d = S_IDLE;
      end
      S_BUS: begin
        if (wbm_ack_i || timeout_hit_s) state_d = S_RESP;
        else                            state_d = S_BUS;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
        else           state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered bus and response outputs
  always_comb begin
    live_d      = 1'b1;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          cyc_d = 1'b1;
          we_d  = cmd_we;
          sel_d = cmd_sel;
          adr_d = cmd_adr;
          dat_d = cmd_dat;
          cnt_d = '0;
        end else begin
          cyc_d = 1'b0;
        end
      end
      S_BUS: begin
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end else if (timeout_hit_s) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end
      end
      S_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
        else           rsp_valid_d = 1'b1;
      end
      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  assign cmd_ready = live_q && (state_q == S_IDLE);
  assign busy      = (state_q == S_BUS) || (state_q == S_RESP);
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

endmodule
